// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall sequencer for the AURA16 five-stage pipeline: drives per-stage
// Enable/CLR pairs, arbitrates memory waits, branches, load-use hazards and jumps.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [2:0]  ID_Rs,
    input  logic [2:0]  ID_Rt,
    input  logic        ID_Uses_Rt,
    input  logic        ID_Jump,
    input  logic        EX_Mem_Read,
    input  logic [2:0]  EX_Write_Reg,
    input  logic        EX_Branch_Taken,
    input  logic        MEM_Access,
    input  logic        Mem_Ready,
    output logic        Mem_Req,
    output logic        PC_Enable,
    output logic        IF_ID_Enable,
    output logic        IF_ID_CLR,
    output logic        ID_EX_Enable,
    output logic        ID_EX_CLR,
    output logic        EX_MEM_Enable,
    output logic        EX_MEM_CLR,
    output logic        MEM_WB_Enable,
    output logic        MEM_WB_CLR,
    output logic        Mem_Error,
    output logic [15:0] Stall_Count,
    output logic [15:0] Flush_Count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [15:0]        stall_count_reg, flush_count_reg;

    logic mem_stall, load_use;
    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic exmem_en, exmem_clr, memwb_en, memwb_clr, req;
    logic count_stall, count_flush;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (count_stall && (stall_count_reg != 16'hFFFF))
                stall_count_reg <= stall_count_reg + 16'd1;
            if (count_flush && (flush_count_reg != 16'hFFFF))
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (MEM_Access && !Mem_Ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (Mem_Ready)
                    state_next = RUN;
                else if ((MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST))
                    state_next = ERROR;
                else
                    wait_cnt_next = wait_cnt_reg + 1'b1;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // An access that is not ready stalls everything ahead of WB, whether it is
    // the first cycle (still in RUN) or any later cycle in MEM_WAIT.
    assign mem_stall = !Mem_Ready &&
                       (((state_reg == RUN) && MEM_Access) || (state_reg == MEM_WAIT));

    assign load_use = EX_Mem_Read && (EX_Write_Reg != 3'd0) &&
                      ((EX_Write_Reg == ID_Rs) || (ID_Uses_Rt && (EX_Write_Reg == ID_Rt)));

    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_en   = 1'b1;
        idex_clr  = 1'b0;
        exmem_en  = 1'b1;
        exmem_clr = 1'b0;
        memwb_en  = 1'b1;
        memwb_clr = 1'b0;
        req       = 1'b0;
        if (Reset) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ifid_clr  = 1'b1;
            idex_en   = 1'b0;
            idex_clr  = 1'b1;
            exmem_en  = 1'b0;
            exmem_clr = 1'b1;
            memwb_en  = 1'b0;
            memwb_clr = 1'b1;
        end else if (state_reg == ERROR) begin
            // Frozen: nothing moves and nothing is cleared until reset.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            req = MEM_Access;
            if (mem_stall) begin
                // Bubble into WB so the held EX/MEM result is not written twice.
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                memwb_clr = 1'b1;
            end else if (EX_Branch_Taken) begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (load_use) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_clr = 1'b1;
            end else if (ID_Jump) begin
                ifid_clr = 1'b1;
            end
        end
    end

    assign count_stall = !pc_en && ((state_reg == RUN) || (state_reg == MEM_WAIT));
    assign count_flush = ifid_clr && !Reset;

    assign Mem_Req       = req;
    assign PC_Enable     = pc_en;
    assign IF_ID_Enable  = ifid_en;
    assign IF_ID_CLR     = ifid_clr;
    assign ID_EX_Enable  = idex_en;
    assign ID_EX_CLR     = idex_clr;
    assign EX_MEM_Enable = exmem_en;
    assign EX_MEM_CLR    = exmem_clr;
    assign MEM_WB_Enable = memwb_en;
    assign MEM_WB_CLR    = memwb_clr;
    assign Mem_Error     = (state_reg == ERROR);
    assign Stall_Count   = stall_count_reg;
    assign Flush_Count   = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus
// randomized cycles compared against a rule-level reference model.
module tb_pipeline_hazard_controller;

    localparam int T = 4;
    // {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr, Req}
    localparam logic [9:0] RST_OUTS = 10'b0_0_1_0_1_0_1_0_1_0;

    logic        clk = 1'b0;
    logic        Reset;
    logic [2:0]  ID_Rs, ID_Rt, EX_Write_Reg;
    logic        ID_Uses_Rt, ID_Jump, EX_Mem_Read, EX_Branch_Taken, MEM_Access, Mem_Ready;
    logic        Mem_Req, PC_Enable, IF_ID_Enable, IF_ID_CLR, ID_EX_Enable, ID_EX_CLR;
    logic        EX_MEM_Enable, EX_MEM_CLR, MEM_WB_Enable, MEM_WB_CLR, Mem_Error;
    logic [15:0] Stall_Count, Flush_Count;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Uses_Rt(ID_Uses_Rt), .ID_Jump(ID_Jump),
        .EX_Mem_Read(EX_Mem_Read), .EX_Write_Reg(EX_Write_Reg),
        .EX_Branch_Taken(EX_Branch_Taken), .MEM_Access(MEM_Access), .Mem_Ready(Mem_Ready),
        .Mem_Req(Mem_Req), .PC_Enable(PC_Enable),
        .IF_ID_Enable(IF_ID_Enable), .IF_ID_CLR(IF_ID_CLR),
        .ID_EX_Enable(ID_EX_Enable), .ID_EX_CLR(ID_EX_CLR),
        .EX_MEM_Enable(EX_MEM_Enable), .EX_MEM_CLR(EX_MEM_CLR),
        .MEM_WB_Enable(MEM_WB_Enable), .MEM_WB_CLR(MEM_WB_CLR),
        .Mem_Error(Mem_Error), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    logic [9:0] outs;
    assign outs = {PC_Enable, IF_ID_Enable, IF_ID_CLR, ID_EX_Enable, ID_EX_CLR,
                   EX_MEM_Enable, EX_MEM_CLR, MEM_WB_Enable, MEM_WB_CLR, Mem_Req};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = timed out.
    int m_mode, m_wcnt, m_stall, m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_out();
        logic lu, stall;
        if (m_mode == 2) return 10'b0;
        stall = !Mem_Ready && ((m_mode == 0 && MEM_Access) || m_mode == 1);
        lu = EX_Mem_Read && EX_Write_Reg != 0 &&
             (EX_Write_Reg == ID_Rs || (ID_Uses_Rt && EX_Write_Reg == ID_Rt));
        if (stall)           return {9'b0_0_0_0_0_0_0_1_1, MEM_Access};
        if (EX_Branch_Taken) return {9'b1_1_1_1_1_1_0_1_0, MEM_Access};
        if (lu)              return {9'b0_0_0_1_1_1_0_1_0, MEM_Access};
        if (ID_Jump)         return {9'b1_1_1_1_0_1_0_1_0, MEM_Access};
        return {9'b1_1_0_1_0_1_0_1_0, MEM_Access};
    endfunction

    task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                         input logic jmp, input logic mrd, input logic [2:0] wr,
                         input logic br, input logic acc, input logic rdy);
        ID_Rs = rs; ID_Rt = rt; ID_Uses_Rt = urt; ID_Jump = jmp; EX_Mem_Read = mrd;
        EX_Write_Reg = wr; EX_Branch_Taken = br; MEM_Access = acc; Mem_Ready = rdy;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one clock.
    task automatic cycle(input string tag);
        logic [9:0] e;
        #1;
        e = model_out();
        check({tag, " outs"}, 32'(outs), 32'(e));
        check({tag, " mem_error"}, 32'(Mem_Error), (m_mode == 2) ? 1 : 0);
        check({tag, " stall_count"}, 32'(Stall_Count), m_stall);
        check({tag, " flush_count"}, 32'(Flush_Count), m_flush);
        if (m_mode != 2 && !e[9]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (e[7]) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        if (m_mode == 0) begin
            if (MEM_Access && !Mem_Ready) begin m_mode = 1; m_wcnt = 0; end
        end else if (m_mode == 1) begin
            if (Mem_Ready) m_mode = 0;
            else if (m_wcnt == T - 1) m_mode = 2;
            else m_wcnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("reset outs", 32'(outs), 32'(RST_OUTS));
        @(negedge clk);
        check("reset stall_count", 32'(Stall_Count), 0);
        check("reset flush_count", 32'(Flush_Count), 0);
        check("reset mem_error", 32'(Mem_Error), 0);
        Reset = 1'b0;
        m_mode = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    endtask

    logic [2:0] r_rs, r_wr;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        @(negedge clk);
        do_reset();

        // Idle, then load-use hazard lasting one cycle.
        drive(1, 2, 1, 0, 0, 0, 0, 0, 1); cycle("idle");
        drive(3, 5, 0, 0, 1, 3, 0, 0, 1); cycle("loaduse");
        check("loaduse stall=1", 32'(Stall_Count), 1);
        drive(3, 5, 0, 0, 0, 3, 0, 0, 1); cycle("after loaduse");
        drive(0, 0, 1, 0, 1, 0, 0, 0, 1); cycle("loaduse r0");
        drive(1, 4, 1, 0, 1, 4, 0, 0, 1); cycle("loaduse rt");
        drive(1, 4, 0, 0, 1, 4, 0, 0, 1); cycle("rt unused");
        check("stall after rt", 32'(Stall_Count), 2);

        // Branch beats simultaneous load-use and jump.
        do_reset();
        drive(3, 0, 0, 1, 1, 3, 1, 0, 1); cycle("branch prio");
        check("branch flush=1", 32'(Flush_Count), 1);
        check("branch stall=0", 32'(Stall_Count), 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 1); cycle("jump");
        check("jump flush=2", 32'(Flush_Count), 2);

        // Three-cycle memory wait, branch request during wait is suppressed.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("memwait");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); cycle("mem ready");
        check("memwait stall=3", 32'(Stall_Count), 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("post wait run");

        // Timeout into ERROR after one RUN and T wait cycles.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 1 + T; i++) cycle("timeout");
        check("timeout mem_error", 32'(Mem_Error), 1);
        check("timeout outs", 32'(outs), 0);
        drive(0, 0, 0, 1, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle("error hold");

        // Asynchronous reset in the second wait cycle.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("pre wait");
        cycle("wait1");
        #2 Reset = 1'b1;
        #1 check("async reset outs", 32'(outs), 32'(RST_OUTS));
        check("async reset stall", 32'(Stall_Count), 0);
        @(negedge clk);
        Reset = 1'b0;
        m_mode = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("after async reset");

        // Stall counter saturation via a held load-use hazard.
        do_reset();
        drive(2, 0, 0, 0, 1, 2, 0, 0, 1);
        for (int i = 0; i < 65534; i++) cycle("sat run");
        check("sat fffe", 32'(Stall_Count), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) cycle("sat top");
        check("sat ffff", 32'(Stall_Count), 32'h0000_FFFF);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 2) do_reset();
            r_rs = 3'($urandom_range(0, 7));
            r_wr = ($urandom_range(0, 2) == 0) ? r_rs : 3'($urandom_range(0, 7));
            drive(r_rs, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), r_wr,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
